// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus per-bit tick-counted debounce filter for board switches.
// Defining SW_EDGE_EN adds registered per-bit rise/fall strobes alongside upd.
module sw_debounce #(
    parameter int WIDTH        = 10,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] SW_db,
    output logic             upd
`ifdef SW_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_t;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [PW-1:0]    r_pre;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_db;
    logic             r_upd;

    logic             w_tick;
    state_t           w_state   [WIDTH];
    logic [CW-1:0]    w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_db_nxt;

    assign w_tick = (r_pre == PRE_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // A bit is COUNTING whenever its synchronised level disagrees with the filtered output;
    // any agreeing cycle drops it back to STABLE and discards the partial count.
    always_comb begin
        w_db_nxt = r_db;
        for (int i = 0; i < WIDTH; i++) begin
            w_state[i]   = (r_sync2[i] != r_db[i]) ? ST_COUNTING : ST_STABLE;
            w_cnt_nxt[i] = '0;
            case (w_state[i])
                ST_STABLE: begin
                    w_cnt_nxt[i] = '0;
                end
                ST_COUNTING: begin
                    if (w_tick) begin
                        if (r_cnt[i] == CNT_MAX) begin
                            w_db_nxt[i] = r_sync2[i];
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i];
                    end
                end
                default: begin
                    w_cnt_nxt[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_upd   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= SW;
            r_sync2 <= r_sync1;
            r_db    <= w_db_nxt;
            r_upd   <= (w_db_nxt != r_db);
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign SW_db = r_db;
    assign upd   = r_upd;

`ifdef SW_EDGE_EN
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_db_nxt & ~r_db;
            r_fall <= ~w_db_nxt & r_db;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`endif

endmodule
